adc_channel_sequencer: RTL

Selects which external-ADC channel result is presented to the seven-segment display path. It replaces the free-running button counter with a clocked sequencer that supports manual stepping and timed auto-scan. Each shown value is a registered snapshot that refreshes only on channel change or on a fresh sample of the selected channel. It sits between `external_adc` (per-channel BCD words) and `DigitToSeg`, with debounced button ticks as control inputs.

---
 rtl/adc_channel_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/adc_channel_sequencer.sv
// Channel sequencer between external_adc and the seven-segment path: manual stepping or
// timed auto-scan, with a registered snapshot of the selected channel. Option: ADC_SEQ_STALE_DETECT_EN.
module adc_channel_sequencer #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned DW           = 16,
    parameter int unsigned DWELL_CYCLES = 200_000_000,
    parameter int unsigned STALE_CYCLES = 100_000_000,
    localparam int unsigned CW          = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 next_tick,
    input  logic                 mode_tick,
    input  logic [N_CH*DW-1:0]   ch_data,
    input  logic [N_CH-1:0]      ch_valid,
    output logic [DW-1:0]        disp_data,
    output logic [CW-1:0]        disp_ch,
    output logic                 disp_valid,
    output logic                 auto_mode,
    output logic                 stale
);

    localparam int unsigned DCW = $clog2(DWELL_CYCLES);

    typedef enum logic [0:0] {StManual, StAuto} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   sel_q, sel_d;
    logic [DCW-1:0]  dwell_q, dwell_d;
    logic [DW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic            adv, load, expire, sel_valid, force_e;
    logic [DW-1:0]   word;

    // Mode toggle wins over both the manual tick and dwell expiry.
    assign expire = (state_q == StAuto) && (dwell_q == DCW'(DWELL_CYCLES - 1));
    assign adv    = !mode_tick && (next_tick || expire);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dwell_d = '0;
        if (mode_tick) begin
            state_d = (state_q == StManual) ? StAuto : StManual;
        end else if (state_q == StAuto && !adv) begin
            dwell_d = dwell_q + 1'b1;
        end
        if (adv) begin
            sel_d = (sel_q == CW'(N_CH - 1)) ? '0 : sel_q + 1'b1;
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        word      = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel_q == CW'(k)) sel_valid = ch_valid[k];
            if (sel_d == CW'(k)) word = ch_data[k*DW +: DW];
        end
    end

    assign load = adv || sel_valid;

    always_comb begin
        valid_d = load;
        data_d  = data_q;
        if (load) begin
            data_d = word;
        end else if (force_e) begin
            data_d = {DW/4{4'hE}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StManual;
            sel_q   <= '0;
            dwell_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef ADC_SEQ_STALE_DETECT_EN
    localparam int unsigned SCW = $clog2(STALE_CYCLES + 1);

    logic [SCW-1:0] stale_cnt_q, stale_cnt_d;
    logic           stale_q, stale_d;

    // Counter saturates at the timeout; the forced pattern is rewritten while stale holds.
    always_comb begin
        stale_cnt_d = stale_cnt_q;
        stale_d     = stale_q;
        if (load) begin
            stale_cnt_d = '0;
            stale_d     = 1'b0;
        end else begin
            if (stale_cnt_q != SCW'(STALE_CYCLES)) stale_cnt_d = stale_cnt_q + 1'b1;
            if (stale_cnt_d == SCW'(STALE_CYCLES)) stale_d = 1'b1;
        end
    end

    assign force_e = stale_d && !load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stale_cnt_q <= '0;
            stale_q     <= 1'b0;
        end else begin
            stale_cnt_q <= stale_cnt_d;
            stale_q     <= stale_d;
        end
    end

    assign stale = stale_q;
`else
    logic unused_stale_cfg;
    assign unused_stale_cfg = (STALE_CYCLES == 0);
    assign force_e          = 1'b0;
    assign stale            = 1'b0;
`endif

    assign disp_data  = data_q;
    assign disp_ch    = sel_q;
    assign disp_valid = valid_q;
    assign auto_mode  = (state_q == StAuto);

endmodule
